// File: rtl/cp0_pkg.sv
// cp0_pkg: ExcCodes, CP0 register indices, mem_exc bit positions and FSM states
package cp0_pkg;
  localparam logic [4:0] EXC_INT = 5'd0, EXC_ADEL = 5'd4, EXC_ADES = 5'd5, EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP = 5'd9, EXC_RI = 5'd10, EXC_OV = 5'd12;
  localparam int CP0_BADVADDR = 8, CP0_COMPARE = 11, CP0_STATUS = 12, CP0_CAUSE = 13, CP0_EPC = 14;
  localparam int EB_ADEL_IF = 0, EB_RI = 1, EB_OV = 2, EB_SYS = 3, EB_BP = 4, EB_ADEL_LD = 5, EB_ADES = 6;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_COMMIT = 2'd1, S_DRAIN = 2'd2} state_t;
endpackage

// File: rtl/exc_int_sync.sv
// exc_int_sync: two-flop synchroniser for the six hardware interrupt lines
module exc_int_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] ext_int,
  output logic [5:0] ext_int_s
);
  logic [5:0] meta;
  always_ff @(posedge clk)
    if (rst) {ext_int_s, meta} <= '0;
    else {ext_int_s, meta} <= {meta, ext_int};
endmodule

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: exception/interrupt arbitration and CP0 commit; TIMER_INT_EN adds Compare and the IP7 timer
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter int              WIDTH      = 32,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       ext_int,
  input  logic             mem_valid,
  input  logic [WIDTH-1:0] mem_pc,
  input  logic             mem_in_ds,
  input  logic [6:0]       mem_exc,
  input  logic [WIDTH-1:0] mem_badaddr,
  input  logic             mem_eret,
  input  logic [WIDTH-1:0] status_in,
  input  logic [WIDTH-1:0] cause_in,
  input  logic [WIDTH-1:0] epc_in,
  input  logic [WIDTH-1:0] count_in,
  input  logic             compare_we,
  input  logic [WIDTH-1:0] compare_wdata,
  output logic [WIDTH-1:0] cp0_we,
  output logic [4:0]       exc_code,
  output logic [WIDTH-1:0] epc_out,
  output logic [WIDTH-1:0] badvaddr_out,
  output logic             exl_out,
  output logic             bd_out,
  output logic [5:0]       hw_int_out,
  output logic [WIDTH-1:0] compare_data,
  output logic             flush,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc
);
  state_t state;
  logic [5:0] ext_int_s;
  logic [6:0] flags;
  logic [4:0] code;
  logic [WIDTH-1:0] we;
  logic timer_int, intr, exc, take, addr;
  exc_int_sync u_sync (.clk(clk), .rst(rst), .ext_int(ext_int), .ext_int_s(ext_int_s));
`ifdef TIMER_INT_EN
  logic unused;
  assign unused = ^{status_in[WIDTH-1:16], status_in[7:2], cause_in[WIDTH-1:10], cause_in[7:0]};
  always_ff @(posedge clk)
    if (rst) begin
      compare_data <= '0;
      timer_int <= 1'b0;
    end else if (compare_we) begin
      compare_data <= compare_wdata;
      timer_int <= 1'b0;
    end else if (compare_data != '0 && count_in == compare_data) timer_int <= 1'b1;
`else
  logic unused;
  assign unused = ^{status_in[WIDTH-1:16], status_in[7:2], cause_in[WIDTH-1:10], cause_in[7:0],
                    compare_we, compare_wdata, count_in};
  assign compare_data = '0;
  assign timer_int = 1'b0;
`endif
  assign hw_int_out = {ext_int_s[5] | timer_int, ext_int_s[4:0]};
  always_comb begin
    flags = mem_valid ? mem_exc : '0;
    intr = mem_valid & status_in[0] & ~status_in[1] & (|({hw_int_out, cause_in[9:8]} & status_in[15:8]));
    exc = intr | (|flags);
    take = (state == S_IDLE) & (exc | (mem_valid & mem_eret));
    // BadVAddr is written only when an address error is the winning cause
    addr = ~intr & (flags[EB_ADEL_IF] | (~|flags[EB_BP:EB_RI] & (flags[EB_ADEL_LD] | flags[EB_ADES])));
    code = intr ? EXC_INT : flags[EB_ADEL_IF] ? EXC_ADEL : flags[EB_RI] ? EXC_RI : flags[EB_OV] ? EXC_OV :
           flags[EB_SYS] ? EXC_SYS : flags[EB_BP] ? EXC_BP : flags[EB_ADEL_LD] ? EXC_ADEL : EXC_ADES;
    we = '0;
    we[CP0_STATUS] = 1'b1;
    we[CP0_CAUSE] = exc;
    we[CP0_EPC] = exc;
    we[CP0_BADVADDR] = addr;
  end
  always_ff @(posedge clk)
    if (rst || !take) begin
      cp0_we <= '0;
      exc_code <= '0;
      epc_out <= '0;
      badvaddr_out <= '0;
      exl_out <= 1'b0;
      bd_out <= 1'b0;
      flush <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc <= '0;
    end else begin
      cp0_we <= we;
      exc_code <= exc ? code : EXC_INT;
      epc_out <= exc ? (mem_in_ds ? mem_pc - WIDTH'(4) : mem_pc) : '0;
      badvaddr_out <= !addr ? '0 : flags[EB_ADEL_IF] ? mem_pc : mem_badaddr;
      exl_out <= exc;
      bd_out <= exc & mem_in_ds;
      flush <= 1'b1;
      redirect_valid <= 1'b1;
      redirect_pc <= exc ? EXC_VECTOR : epc_in;
    end
  always_ff @(posedge clk)
    if (rst) state <= S_IDLE;
    else state <= take ? S_COMMIT : state == S_COMMIT ? S_DRAIN : S_IDLE;
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb_cp0_exc_ctrl: directed plus random stimulus against a table-driven reference model
module tb_cp0_exc_ctrl;
  logic clk = 1'b0, rst;
  logic [5:0] ext_int;
  logic mem_valid, mem_in_ds, mem_eret, compare_we;
  logic [31:0] mem_pc, mem_badaddr, status_in, cause_in, epc_in, count_in, compare_wdata;
  logic [6:0] mem_exc;
  logic [31:0] cp0_we, epc_out, badvaddr_out, compare_data, redirect_pc;
  logic [4:0] exc_code;
  logic exl_out, bd_out, flush, redirect_valid;
  logic [5:0] hw_int_out;
  int checks = 0, failures = 0;
  logic [5:0] h1, h2;
  logic m_timer;
  logic [31:0] m_cmp, cnt;
  int m_busy;
  int code_tab[7] = '{4, 10, 12, 8, 9, 4, 5};

  cp0_exc_ctrl dut (
    .clk(clk), .rst(rst), .ext_int(ext_int), .mem_valid(mem_valid), .mem_pc(mem_pc),
    .mem_in_ds(mem_in_ds), .mem_exc(mem_exc), .mem_badaddr(mem_badaddr), .mem_eret(mem_eret),
    .status_in(status_in), .cause_in(cause_in), .epc_in(epc_in), .count_in(count_in),
    .compare_we(compare_we), .compare_wdata(compare_wdata), .cp0_we(cp0_we), .exc_code(exc_code),
    .epc_out(epc_out), .badvaddr_out(badvaddr_out), .exl_out(exl_out), .bd_out(bd_out),
    .hw_int_out(hw_int_out), .compare_data(compare_data), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    ext_int = 0; mem_valid = 0; mem_pc = 0; mem_in_ds = 0; mem_exc = 0; mem_badaddr = 0;
    mem_eret = 0; status_in = 0; cause_in = 0; epc_in = 0; compare_we = 0; compare_wdata = 0;
  endtask

  // one clock: predict from current inputs and model state, advance, compare everything
  task automatic cycle();
    logic [5:0] hw;
    logic intr, commit;
    int win;
    logic [31:0] e_we, e_epc, e_badv, e_rpc;
    logic [4:0] e_code;
    logic e_exl, e_bd, e_fl;
    hw = {h2[5] | m_timer, h2[4:0]};
    {e_we, e_epc, e_badv, e_rpc, e_code, e_exl, e_bd, e_fl} = '0;
    commit = 0;
    win = -1;
    if (!rst && m_busy == 0 && mem_valid) begin
      intr = status_in[0] && !status_in[1] && (({hw, cause_in[9:8]} & status_in[15:8]) != 0);
      if (!intr) for (int i = 0; i < 7; i++) if (win < 0 && mem_exc[i]) win = i;
      if (intr || win >= 0) begin
        commit = 1;
        e_code = intr ? 5'd0 : 5'(code_tab[win]);
        e_we = 32'h7000 | ((!intr && (win == 0 || win >= 5)) ? 32'h100 : 32'h0);
        e_epc = mem_in_ds ? mem_pc - 4 : mem_pc;
        e_bd = mem_in_ds;
        e_exl = 1;
        e_badv = intr ? 32'h0 : win == 0 ? mem_pc : win >= 5 ? mem_badaddr : 32'h0;
        e_rpc = 32'hBFC00380;
      end else if (mem_eret) begin
        commit = 1;
        e_we = 32'h1000;
        e_rpc = epc_in;
      end
      e_fl = commit;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      h1 = 0; h2 = 0; m_timer = 0; m_cmp = 0; m_busy = 0;
    end else begin
`ifdef TIMER_INT_EN
      if (compare_we) begin m_cmp = compare_wdata; m_timer = 0; end
      else if (m_cmp != 0 && count_in == m_cmp) m_timer = 1;
`endif
      h2 = h1; h1 = ext_int;
      m_busy = commit ? 2 : (m_busy > 0 ? m_busy - 1 : 0);
    end
    check("cp0_we", cp0_we, e_we);
    check("exc_code", 32'(exc_code), 32'(e_code));
    check("epc_out", epc_out, e_epc);
    check("badvaddr", badvaddr_out, e_badv);
    check("exl_out", 32'(exl_out), 32'(e_exl));
    check("bd_out", 32'(bd_out), 32'(e_bd));
    check("flush", 32'(flush), 32'(e_fl));
    check("redirect_valid", 32'(redirect_valid), 32'(e_fl));
    check("redirect_pc", redirect_pc, e_rpc);
    check("hw_int_out", 32'(hw_int_out), 32'({h2[5] | m_timer, h2[4:0]}));
    check("compare_data", compare_data, m_cmp);
  endtask

  initial begin
    h1 = 0; h2 = 0; m_timer = 0; m_cmp = 0; m_busy = 0; cnt = 0; count_in = 0;
    idle_inputs();
    rst = 1;
    cycle(); cycle();
    check("rst_flush", 32'(flush), 32'h0);
    rst = 0;
    // Ov, not in a delay slot
    mem_valid = 1; mem_pc = 32'h80001000; mem_exc = 7'b0000100;
    cycle();
    check("ov_code", 32'(exc_code), 32'd12);
    check("ov_epc", epc_out, 32'h80001000);
    check("ov_we", cp0_we & 32'h7000, 32'h7000);
    check("ov_rpc", redirect_pc, 32'hBFC00380);
    check("ov_flush", 32'(flush), 32'h1);
    idle_inputs();
    cycle();
    check("ov_flush_one", 32'(flush), 32'h0);
    cycle();
    // AdEL_ld in a delay slot
    mem_valid = 1; mem_in_ds = 1; mem_pc = 32'h80002004; mem_badaddr = 32'h3; mem_exc = 7'b0100000;
    cycle();
    check("adel_epc", epc_out, 32'h80002000);
    check("adel_bd", 32'(bd_out), 32'h1);
    check("adel_badv", badvaddr_out, 32'h3);
    check("adel_we8", 32'(cp0_we[8]), 32'h1);
    idle_inputs();
    cycle(); cycle();
    // RI and Sys together, then an exception held through COMMIT and DRAIN
    mem_valid = 1; mem_pc = 32'h80000040; mem_exc = 7'b0001010;
    cycle();
    check("ri_sys_code", 32'(exc_code), 32'd10);
    mem_exc = 7'b0000100;
    cycle();
    cycle();
    check("drain_ignored", 32'(flush), 32'h0);
    idle_inputs();
    cycle(); cycle(); cycle();
    // interrupt on IP4 (ext_int[2])
    status_in = 32'h0000FF01; ext_int = 6'b000100;
    cycle(); cycle();
    check("hw_int_2", 32'(hw_int_out[2]), 32'h1);
    mem_valid = 1; mem_pc = 32'h80000100;
    cycle();
    check("int_code", 32'(exc_code), 32'd0);
    check("int_flush", 32'(flush), 32'h1);
    mem_valid = 0;
    cycle(); cycle();
    status_in = 32'h0000FF03; mem_valid = 1;
    cycle();
    check("int_exl_masked", 32'(flush), 32'h0);
    idle_inputs();
    cycle(); cycle(); cycle();
    // ERET
    mem_valid = 1; mem_eret = 1; epc_in = 32'h80003000;
    cycle();
    check("eret_we", cp0_we, 32'h1000);
    check("eret_exl", 32'(exl_out), 32'h0);
    check("eret_rpc", redirect_pc, 32'h80003000);
    idle_inputs();
    cycle(); cycle();
    // timer match, then a Compare write colliding with a match
    compare_we = 1; compare_wdata = 5; count_in = 0;
    cycle();
    compare_we = 0;
    for (int i = 1; i <= 5; i++) begin count_in = i; cycle(); end
`ifdef TIMER_INT_EN
    check("timer_set", 32'(hw_int_out[5]), 32'h1);
`endif
    compare_we = 1; compare_wdata = 8; count_in = 7;
    cycle();
    count_in = 8;
    cycle();
    compare_we = 0; count_in = 9;
    cycle();
    check("timer_write_wins", 32'(hw_int_out[5]), 32'h0);
    // reset while in COMMIT
    mem_valid = 1; mem_pc = 32'h80004000; mem_exc = 7'b0000100;
    cycle();
    idle_inputs();
    rst = 1;
    cycle();
    check("rst_commit_we", cp0_we, 32'h0);
    check("rst_commit_flush", 32'(flush), 32'h0);
    rst = 0;
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      cnt = cnt + 1;
      count_in = cnt;
      rst = ($urandom_range(0, 199) == 0);
      ext_int = ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'h0;
      mem_valid = ($urandom_range(0, 3) != 0);
      mem_pc = $urandom & 32'hFFFFFFFC;
      mem_in_ds = $urandom_range(0, 1) == 1;
      mem_exc = ($urandom_range(0, 2) == 0) ? 7'($urandom) & 7'($urandom) : 7'h0;
      mem_badaddr = $urandom;
      mem_eret = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 3))
        0: status_in = 32'h0000FF01;
        1: status_in = 32'h0000FF03;
        2: status_in = 32'h00008001;
        default: status_in = $urandom;
      endcase
      cause_in = $urandom;
      epc_in = $urandom;
      compare_we = ($urandom_range(0, 29) == 0);
      compare_wdata = ($urandom_range(0, 7) == 0) ? 32'h0 : cnt + $urandom_range(0, 20);
      cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
